ov7670_sccb_master: RTL and testbench
=====================================

Name: ov7670_sccb_master

Overview:
SCCB 3-phase write master. Accepts one (register address, data) pair from the camera config sequencer via a start/ready handshake and serialises it onto the OV7670 SIOC/SIOD pins as: start, device ID, register address, data, stop. Sits directly downstream of the config sequencer and directly upstream of the top-level SIOD tristate buffer and SIOC pin. Reports a sticky per-transaction NACK flag from the don't-care bits.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz
SCCB_FREQ, 100_000, SIOC bit rate in Hz
DEV_ADDR, 8'h42, SCCB write ID byte, sent verbatim MSB first

Ports:
clk  input  1  system clock
reset  input  1  reset
sccb_start  input  1  single-cycle request; sampled only while sccb_ready=1
sccb_addr  input  8  register address, latched on accepted start
sccb_data  input  8  register data, latched on accepted start
sccb_ready  output  1  1 = idle, can accept a start
sccb_nack  output  1  1 = at least one don't-care bit of the last transaction sampled high
sioc  output  1  SCCB clock pin
siod_out  output  1  SIOD value when driven
siod_oe  output  1  1 = drive siod_out; 0 = release (pull-up)
siod_in  input  1  SIOD pin readback, asynchronous to clk

Behaviour:
- Reset: asynchronous, active-high; clock clk. Reset values: sccb_ready=1, sccb_nack=0, sioc=1, siod_out=1, siod_oe=1, all state/counters 0, FSM in IDLE.
- Reset mid-transfer aborts immediately to the reset values. No stop condition is generated.
- QTR = CLK_FREQ/(4*SCCB_FREQ), integer division. Elaboration error if QTR<2. With the defaults, QTR=62.
- A quarter counter runs only outside IDLE. It restarts at 0 on accept and emits a tick every QTR cycles. Every state below lasts whole quarters (q0..q3). Outputs change only on tick boundaries.
- Accept: the edge where sccb_start=1 and sccb_ready=1. On that edge:
  - latch shift register {DEV_ADDR, sccb_addr, sccb_data}
  - sccb_ready<=0, sccb_nack<=0, go to START.
- sccb_start while sccb_ready=0 is ignored, with no queuing. The upstream sequencer rechecks ready 3 cycles after its start pulse, so ready must be low from the cycle after accept. This is satisfied because ready is registered.
- Bus pin sequence per transaction:
  - IDLE: sioc=1, siod_oe=1, siod_out=1.
  - START (1 quarter each): q0 siod_out=0 (sioc=1); q1 hold; q2 sioc=0; q3 hold.
  - BIT, 27 bits = 3 phases × (8 data bits MSB first + 1 don't-care bit):
    - q0: sioc=0, present the bit. Data bit: siod_oe=1, siod_out=bit. Don't-care bit (indices 8, 17, 26): siod_oe=0.
    - q1: sioc=1.
    - q2: sioc=1. On a don't-care bit, sample the synchronised siod_in; if it is 1, set sccb_nack.
    - q3: sioc=0.
  - STOP: q0 siod_oe=1, siod_out=0, sioc=0; q1 sioc=1; q2 siod_out=1; q3 hold.
  - BUF: 4 quarters with lines idle (bus-free time). Then sccb_ready<=1 and return to IDLE.
- siod_in passes through a 2-flop synchroniser before sampling.
- Total: 1+27+1+1 = 30 bit-slots = 120 quarters. sccb_ready is low for exactly 120*QTR cycles after accept and reads high on the following cycle. A start asserted on that cycle is accepted (back-to-back).
- sccb_nack updates only during BIT and holds until the next accept.
- Bit counter: 5 bits, 0..26. Transition to STOP after bit 26 q3, with no wrap.

Test Plan:
- Reset: hold reset, then release -> sioc=1, siod_oe=1, siod_out=1, sccb_ready=1, sccb_nack=0.
- Basic write (CLK_FREQ=4000, SCCB_FREQ=100, QTR=10): start with addr=8'h12, data=8'h80, siod_in tied 0.
  - Bench decodes SIOD on rising SIOC: 0x42,X,0x12,X,0x80,X.
  - Start and stop conditions seen; ready low for exactly 1200 cycles; nack=0.
- Don't-care drive: same transfer -> siod_oe=0 exactly during quarters of bits 8, 17, 26 and 1 elsewhere; SIOD never changes while sioc=1 except at start/stop.
- NACK: siod_in=1 only during phase 2 don't-care bit -> sccb_nack=1 at ready rise; next transaction with siod_in=0 -> nack cleared at accept and stays 0.
- Handshake corners:
  - start pulsed mid-transfer -> ignored, bus unchanged.
  - start on the first ready-high cycle -> accepted, next START begins.
  - drive the upstream config sequencer with a 3-entry ROM -> 3 correct frames.
- Reset mid-transfer: assert reset during phase 2 bit 3 -> next cycle sioc=1, siod_oe=1, siod_out=1, ready=1; a new start afterwards produces a complete, correct frame.

Source files
------------

// File: rtl/ov7670_sccb_master_if.sv
// rtl/ov7670_sccb_master_if.sv - handshake and SCCB pin bundle for the OV7670 SCCB write master
interface ov7670_sccb_master_if;
  logic       sccb_start;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_ready;
  logic       sccb_nack;
  logic       sioc;
  logic       siod_out;
  logic       siod_oe;
  logic       siod_in;

  // Sequencer / pad side: issues requests and returns the SIOD readback
  modport master (
    output sccb_start, sccb_addr, sccb_data, siod_in,
    input  sccb_ready, sccb_nack, sioc, siod_out, siod_oe
  );

  // Write master side
  modport slave (
    input  sccb_start, sccb_addr, sccb_data, siod_in,
    output sccb_ready, sccb_nack, sioc, siod_out, siod_oe
  );
endinterface

// File: rtl/ov7670_sccb_master.sv
// rtl/ov7670_sccb_master.sv - SCCB 3-phase write master (start, ID, register, data, stop)
module ov7670_sccb_master #(
  parameter int          CLK_FREQ  = 25_000_000,
  parameter int          SCCB_FREQ = 100_000,
  parameter logic [7:0]  DEV_ADDR  = 8'h42
) (
  input logic               clk,
  input logic               reset,
  ov7670_sccb_master_if.slave bus
);

  localparam int QTR = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QW  = (QTR < 2) ? 1 : $clog2(QTR);
  localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

  if (QTR < 2) begin : g_qtr_check
    $error("ov7670_sccb_master: CLK_FREQ/(4*SCCB_FREQ) must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_BUF} state_t;

  state_t        r_state;
  logic [1:0]    r_quarter;
  logic [4:0]    r_bit;
  logic [QW-1:0] r_qcnt;
  logic [23:0]   r_shift;
  logic [1:0]    r_sync;
  logic          r_ready;
  logic          r_nack;
  logic          r_sioc;
  logic          r_oe;
  logic          r_out;

  logic w_accept;
  logic w_tick;
  logic w_dc;

  // Bit slots 8, 17 and 26 are the SCCB don't-care (ACK) positions
  function automatic logic f_dc(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

  // Pin levels {sioc, siod_oe, siod_out} for a given position in the frame
  function automatic logic [2:0] f_pins(input state_t s, input logic [1:0] q,
                                        input logic [4:0] b, input logic d);
    logic [2:0] p;
    p = 3'b111;
    case (s)
      S_START: p = {~q[1], 1'b1, 1'b0};
      S_BIT:   p = f_dc(b) ? {(q == 2'd1) || (q == 2'd2), 1'b0, 1'b1}
                           : {(q == 2'd1) || (q == 2'd2), 1'b1, d};
      S_STOP:  p = {(q != 2'd0), 1'b1, q[1]};
      default: p = 3'b111;
    endcase
    return p;
  endfunction

  assign w_accept = bus.sccb_start & r_ready;
  assign w_tick   = (r_state != S_IDLE) && (r_qcnt == QLAST);
  assign w_dc     = f_dc(r_bit);

  assign bus.sccb_ready = r_ready;
  assign bus.sccb_nack  = r_nack;
  assign bus.sioc       = r_sioc;
  assign bus.siod_oe    = r_oe;
  assign bus.siod_out   = r_out;

  // Frame sequencer: quarter timing, bit shifting, registered pin drive and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_quarter <= 2'd0;
      r_bit     <= 5'd0;
      r_qcnt    <= '0;
      r_shift   <= 24'd0;
      r_sync    <= 2'b00;
      r_ready   <= 1'b1;
      r_nack    <= 1'b0;
      r_sioc    <= 1'b1;
      r_oe      <= 1'b1;
      r_out     <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], bus.siod_in};

      if (r_state == S_IDLE || w_tick) r_qcnt <= '0;
      else                             r_qcnt <= r_qcnt + QW'(1);

      // Slave ACK sampled late in the high phase of each don't-care bit
      if (w_tick && r_state == S_BIT && r_quarter == 2'd2 && w_dc && r_sync[1])
        r_nack <= 1'b1;

      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_state   <= S_START;
          r_quarter <= 2'd0;
          r_bit     <= 5'd0;
          r_shift   <= {DEV_ADDR, bus.sccb_addr, bus.sccb_data};
          r_ready   <= 1'b0;
          r_nack    <= 1'b0;
          {r_sioc, r_oe, r_out} <= 3'b110;
        end
      end else if (w_tick) begin
        r_quarter <= r_quarter + 2'd1;
        if (r_quarter != 2'd3) begin
          {r_sioc, r_oe, r_out} <= f_pins(r_state, r_quarter + 2'd1, r_bit, r_shift[23]);
        end else begin
          case (r_state)
            S_START: begin
              r_state <= S_BIT;
              r_bit   <= 5'd0;
              {r_sioc, r_oe, r_out} <= f_pins(S_BIT, 2'd0, 5'd0, r_shift[23]);
            end
            S_BIT: begin
              if (r_bit == 5'd26) begin
                r_state <= S_STOP;
                {r_sioc, r_oe, r_out} <= f_pins(S_STOP, 2'd0, 5'd0, 1'b0);
              end else if (!w_dc) begin
                r_bit   <= r_bit + 5'd1;
                r_shift <= {r_shift[22:0], 1'b0};
                {r_sioc, r_oe, r_out} <= f_pins(S_BIT, 2'd0, r_bit + 5'd1, r_shift[22]);
              end else begin
                r_bit <= r_bit + 5'd1;
                {r_sioc, r_oe, r_out} <= f_pins(S_BIT, 2'd0, r_bit + 5'd1, r_shift[23]);
              end
            end
            S_STOP: begin
              r_state <= S_BUF;
              {r_sioc, r_oe, r_out} <= 3'b111;
            end
            default: begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              {r_sioc, r_oe, r_out} <= 3'b111;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_master.sv
// tb/tb_ov7670_sccb_master.sv - directed self-checking bench for the SCCB write master
module tb_ov7670_sccb_master;
  localparam int CLK_FREQ  = 4000;
  localparam int SCCB_FREQ = 100;
  localparam int QTR       = 10;
  localparam int FRAME     = 120 * QTR;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ov7670_sccb_master_if bus();

  ov7670_sccb_master #(
    .CLK_FREQ (CLK_FREQ),
    .SCCB_FREQ(SCCB_FREQ),
    .DEV_ADDR (8'h42)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_addr  = 8'h00;
  logic [7:0] exp_data  = 8'h00;
  logic       nack_mode = 1'b0;

  int          c = 0;
  int          last_low = 0;
  int          start_cnt = 0;
  int          stop_cnt = 0;
  int          bitcnt = 0;
  int          pin_err = 0;
  logic [26:0] rx = '0;
  logic        prev_ready = 1'b1;
  logic        prev_sioc = 1'b1;
  logic        prev_line = 1'b1;

  // Slave pulls SIOD high only across the phase-2 don't-care slot when asked to
  assign bus.siod_in = nack_mode && (c >= 18 * 4 * QTR) && (c < 19 * 4 * QTR);

  // Reference pin levels {sioc, oe, out} for cycle cc after accept
  function automatic logic [2:0] model(input int cc, input logic [7:0] a, input logic [7:0] d);
    int k, slot, q, b, ph, pos;
    logic [23:0] fr;
    fr = {8'h42, a, d};
    k = cc / QTR; slot = k / 4; q = k % 4;
    if (slot == 0) return {(q < 2), 1'b1, 1'b0};
    if (slot <= 27) begin
      b = slot - 1; ph = b / 9; pos = b % 9;
      if (pos == 8) return {(q == 1) || (q == 2), 1'b0, 1'b1};
      return {(q == 1) || (q == 2), 1'b1, fr[23 - (ph * 8 + pos)]};
    end
    if (slot == 28) return {(q >= 1), 1'b1, (q >= 2)};
    return 3'b111;
  endfunction

  // Bus monitor: pin model comparison, start/stop detection and SIOD decode on rising SIOC
  always @(negedge clk) begin
    logic line;
    logic [2:0] m;
    line = bus.siod_oe ? bus.siod_out : bus.siod_in;
    if (!bus.sccb_ready) begin
      if (prev_ready) begin
        start_cnt = 0; stop_cnt = 0; bitcnt = 0; rx = '0; pin_err = 0;
      end
      m = model(c, exp_addr, exp_data);
      if (bus.sioc !== m[2] || bus.siod_oe !== m[1] || (m[1] && bus.siod_out !== m[0]))
        pin_err++;
      c++;
    end else begin
      if (!prev_ready) last_low = c;
      c = 0;
    end
    if (prev_sioc && bus.sioc && line !== prev_line) begin
      if (line == 1'b0) start_cnt++;
      else              stop_cnt++;
    end
    if (!prev_sioc && bus.sioc && bitcnt < 27) begin
      rx = {rx[25:0], line};
      bitcnt++;
    end
    prev_ready = bus.sccb_ready;
    prev_sioc  = bus.sioc;
    prev_line  = line;
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    exp_addr = a; exp_data = d;
    bus.sccb_addr = a; bus.sccb_data = d; bus.sccb_start = 1'b1;
    @(negedge clk);
    bus.sccb_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.sccb_ready && n < FRAME + 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (!bus.sccb_ready) begin
      total++;
      $display("FAIL %s: timeout, ready=%0b required 1", name, bus.sccb_ready);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] a, input logic [7:0] d);
    logic [26:0] want;
    want = {8'h42, 1'b0, a, 1'b0, d, 1'b0};
    total++; if (pin_err !== 0) $display("FAIL %s pins: %0d bad cycles, required 0", name, pin_err); else passed++;
    total++; if (start_cnt !== 1) $display("FAIL %s start: %0d seen, required 1", name, start_cnt); else passed++;
    total++; if (stop_cnt !== 1) $display("FAIL %s stop: %0d seen, required 1", name, stop_cnt); else passed++;
    total++; if (rx !== want) $display("FAIL %s decode: got %h required %h", name, rx, want); else passed++;
    total++; if (last_low !== FRAME) $display("FAIL %s ready_low: %0d cycles, required %0d", name, last_low, FRAME); else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.sioc !== 1'b1) $display("FAIL reset sioc: %b required 1", bus.sioc); else passed++;
    total++; if (bus.siod_oe !== 1'b1) $display("FAIL reset oe: %b required 1", bus.siod_oe); else passed++;
    total++; if (bus.siod_out !== 1'b1) $display("FAIL reset out: %b required 1", bus.siod_out); else passed++;
    total++; if (bus.sccb_ready !== 1'b1) $display("FAIL reset ready: %b required 1", bus.sccb_ready); else passed++;
    total++; if (bus.sccb_nack !== 1'b0) $display("FAIL reset nack: %b required 0", bus.sccb_nack); else passed++;
  endtask

  task automatic test_basic_write();
    issue(8'h12, 8'h80);
    wait_done("basic");
    check_frame("basic", 8'h12, 8'h80);
    total++; if (bus.sccb_nack !== 1'b0) $display("FAIL basic nack: %b required 0", bus.sccb_nack); else passed++;
  endtask

  task automatic test_nack();
    nack_mode = 1'b1;
    issue(8'h3A, 8'h04);
    wait_done("nack_set");
    nack_mode = 1'b0;
    total++; if (bus.sccb_nack !== 1'b1) $display("FAIL nack_set: %b required 1", bus.sccb_nack); else passed++;
    total++; if (pin_err !== 0) $display("FAIL nack_set pins: %0d bad cycles, required 0", pin_err); else passed++;
    issue(8'h40, 8'hD0);
    total++; if (bus.sccb_nack !== 1'b0) $display("FAIL nack_clear_accept: %b required 0", bus.sccb_nack); else passed++;
    wait_done("nack_clear");
    total++; if (bus.sccb_nack !== 1'b0) $display("FAIL nack_clear_end: %b required 0", bus.sccb_nack); else passed++;
    check_frame("nack_clear", 8'h40, 8'hD0);
  endtask

  task automatic test_ignore_mid_start();
    issue(8'h11, 8'h22);
    repeat (300) @(negedge clk);
    bus.sccb_addr = 8'hFF; bus.sccb_data = 8'hFF; bus.sccb_start = 1'b1;
    @(negedge clk);
    bus.sccb_start = 1'b0;
    wait_done("ignore");
    check_frame("ignore", 8'h11, 8'h22);
    repeat (20) @(negedge clk);
    total++;
    if (bus.sccb_ready !== 1'b1 || bus.sioc !== 1'b1 || bus.siod_out !== 1'b1)
      $display("FAIL ignore_idle: ready=%b sioc=%b out=%b required 1 1 1", bus.sccb_ready, bus.sioc, bus.siod_out);
    else passed++;
  endtask

  task automatic test_back_to_back();
    issue(8'h55, 8'hAA);
    wait_done("b2b_first");
    check_frame("b2b_first", 8'h55, 8'hAA);
    exp_addr = 8'h0F; exp_data = 8'hF0;
    bus.sccb_addr = 8'h0F; bus.sccb_data = 8'hF0; bus.sccb_start = 1'b1;
    @(negedge clk);
    bus.sccb_start = 1'b0;
    total++; if (bus.sccb_ready !== 1'b0) $display("FAIL b2b_accept: ready=%b required 0", bus.sccb_ready); else passed++;
    wait_done("b2b_second");
    check_frame("b2b_second", 8'h0F, 8'hF0);
  endtask

  task automatic test_sequencer();
    logic [7:0] rom_a [3];
    logic [7:0] rom_d [3];
    rom_a[0] = 8'h12; rom_d[0] = 8'h04;
    rom_a[1] = 8'h8C; rom_d[1] = 8'h00;
    rom_a[2] = 8'h40; rom_d[2] = 8'hD0;
    for (int i = 0; i < 3; i++) begin
      issue(rom_a[i], rom_d[i]);
      repeat (2) @(negedge clk);
      total++; if (bus.sccb_ready !== 1'b0) $display("FAIL seq%0d recheck: ready=%b required 0", i, bus.sccb_ready); else passed++;
      wait_done("seq");
      check_frame("seq", rom_a[i], rom_d[i]);
    end
  endtask

  task automatic test_reset_mid();
    issue(8'h3A, 8'h04);
    repeat (525) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    total++; if (bus.sioc !== 1'b1) $display("FAIL rstmid sioc: %b required 1", bus.sioc); else passed++;
    total++; if (bus.siod_oe !== 1'b1) $display("FAIL rstmid oe: %b required 1", bus.siod_oe); else passed++;
    total++; if (bus.siod_out !== 1'b1) $display("FAIL rstmid out: %b required 1", bus.siod_out); else passed++;
    total++; if (bus.sccb_ready !== 1'b1) $display("FAIL rstmid ready: %b required 1", bus.sccb_ready); else passed++;
    #2 reset = 1'b0;
    issue(8'h6B, 8'h4A);
    wait_done("rstmid_after");
    check_frame("rstmid_after", 8'h6B, 8'h4A);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sccb_start = 1'b0;
    bus.sccb_addr  = 8'h00;
    bus.sccb_data  = 8'h00;
    test_reset();
    test_basic_write();
    test_nack();
    test_ignore_mid_start();
    test_back_to_back();
    test_sequencer();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
